time_to_bcd: RTL and testbench
==============================

TIME_TO_BCD -- requirements
Module: time_to_bcd

Interface
REQ-001 The block SHALL have parameter WIDTH, default 26, giving the binary input width in bits.
REQ-002 The block SHALL have parameter DIGITS, default 8, giving the number of BCD output digits; 10^DIGITS SHALL exceed 2^WIDTH-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rstN  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  conversion request, sampled only in IDLE.
REQ-006 binIn  input  WIDTH  unsigned binary value, such as the cycle count from the time counter; sampled on the accepting edge.
REQ-007 ready  output  1  high only in IDLE; the block accepts start.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 bcdOut  output  4*DIGITS  packed BCD result; digit 0 in bits [3:0], the most significant digit in the top nibble.

Function
REQ-010 States SHALL be IDLE, CONVERT and FINISH, encoded in a 2-bit state register.
REQ-011 In IDLE with start=1 at rising edge N, the block SHALL latch binIn into a WIDTH-bit shift register, clear a 4*DIGITS-bit BCD scratch register, clear a bit counter and enter CONVERT.
REQ-012 In IDLE with start=0, the block SHALL hold all registers.
REQ-013 Each CONVERT cycle SHALL perform one double-dabble step:
  - add 3 to every scratch digit that is >=5 before the shift;
  - shift the scratch register left 1, with the shift-register MSB entering bit 0;
  - shift the shift register left 1;
  - increment the bit counter.
REQ-014 CONVERT SHALL last exactly WIDTH cycles, edges N+1 through N+WIDTH, and then enter FINISH.
REQ-015 At edge N+WIDTH+1, the block SHALL:
  - load bcdOut from the scratch register;
  - enter FINISH, with done=1 for that one cycle;
  - return to IDLE at the next edge.
  For the default WIDTH, done SHALL be visible in the cycle after edge N+27.
REQ-016 bcdOut SHALL hold its last result until the next completion; it SHALL NOT change during CONVERT.
REQ-017 start SHALL be ignored in CONVERT and FINISH; it is not queued.
REQ-018 A change of binIn after the accepting edge SHALL NOT affect the result in progress.
REQ-019 Every output digit SHALL be in the range 0-9, and no scratch digit SHALL ever exceed 9 after a shift.
REQ-020 The bit counter width SHALL be $clog2(WIDTH+1); it SHALL NOT wrap during a conversion.
REQ-021 ready SHALL be 1 exactly when the state is IDLE and rstN=1.
REQ-022 done and ready SHALL never be high in the same cycle.
REQ-023 Back-to-back operation: start held high SHALL cause a new conversion to be accepted at the first edge back in IDLE, giving a period of WIDTH+3 cycles per conversion.

Reset
REQ-024 rstN=0 SHALL immediately, without waiting for a clock edge, force:
  - state to IDLE;
  - shift register, scratch register, bit counter and bcdOut to 0;
  - done to 0.
REQ-025 Reset asserted mid-CONVERT or in FINISH SHALL abandon the conversion with no done pulse; bcdOut SHALL read 0.
REQ-026 After rstN deasserts, ready SHALL be 1 and the first start SHALL be accepted at the first rising edge.

Verification
REQ-027 binIn=0, pulse start -> done after 27 edges, bcdOut=32'h00000000.
REQ-028 binIn=26'd12345678, start -> bcdOut=32'h12345678; a single done pulse; ready=0 for 28 cycles.
REQ-029 binIn=26'h3FFFFFF (67108863) -> bcdOut=32'h67108863.
  binIn=9 -> 32'h00000009.
  binIn=10 -> 32'h00000010.
REQ-030 Hold start high with binIn changing every cycle:
  - each result equals the binIn sampled on its accepting edge;
  - the done period is 29 cycles;
  - a start pulse during CONVERT is ignored.
REQ-031 Assert rstN=0 at CONVERT cycle 10, between clock edges -> outputs go to 0 asynchronously, no done pulse; after release, a conversion of 99 gives 32'h00000099.
REQ-032 Random binIn, 1000 conversions, checked against an integer reference model -> all digits 0-9, values match.

Source files
------------

// File: rtl/time_to_bcd.sv
// time_to_bcd
//   Sequential binary-to-BCD converter (double dabble, one bit per clock).
//   A WIDTH-bit unsigned value is latched when the block is idle and start
//   is high. It is shifted MSB-first into a 4*DIGITS-bit BCD scratch register
//   over WIDTH cycles. The result is then published on bcdOut together with a
//   one-cycle done pulse.
//
//   Ports
//     clk     in   rising-edge clock
//     rstN    in   asynchronous active-low reset
//     start   in   conversion request, honoured only while ready=1
//     binIn   in   WIDTH-bit unsigned value, captured on the accepting edge
//     ready   out  high while idle and out of reset
//     done    out  one-cycle completion pulse (bcdOut valid alongside it)
//     bcdOut  out  packed BCD result, digit 0 in [3:0]; held between results
//
//   Timing (accept at edge N): the steps happen at edges N+1..N+WIDTH. At edge
//   N+WIDTH+1 the result is loaded and done goes high for one cycle. The block
//   is back in IDLE after edge N+WIDTH+2. A held start therefore gives one
//   conversion every WIDTH+3 cycles.
//
//   DIGITS must be large enough that 10^DIGITS > 2^WIDTH-1. Otherwise the top
//   digit carry is lost.
module time_to_bcd #(
  parameter int WIDTH  = 26,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binIn,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcdOut
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    FINISH  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]   scratch_q, scratch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;

  // Per-digit add-3 correction applied before the shift. Any digit >= 5
  // would become >= 10 after doubling. Adding 3 first makes the doubled
  // value carry into the next digit and leaves a valid 0-9 digit behind.
  logic [BW-1:0] adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign adj[4*g +: 4] = (scratch_q[4*g +: 4] >= 4'd5) ?
                           scratch_q[4*g +: 4] + 4'd3 : scratch_q[4*g +: 4];
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = binIn;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        // WIDTH steps have completed once cnt reaches WIDTH. The extra
        // CONVERT cycle publishes the scratch register.
        if (cnt_q == CW'(WIDTH)) begin
          bcd_d   = scratch_q;
          state_d = FINISH;
        end else begin
          // The carry out of the top digit is discarded by the truncation.
          // It is always 0 when DIGITS is sized correctly.
          scratch_d = BW'({adj, shift_q[WIDTH-1]});
          shift_d   = shift_q << 1;
          cnt_d     = cnt_q + 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
    end
  end

  // ready is gated by rstN so that it reads 0 while reset is held.
  assign ready  = rstN && (state_q == IDLE);
  assign done   = (state_q == FINISH);
  assign bcdOut = bcd_q;

endmodule

// File: tb/tb_time_to_bcd.sv
module tb_time_to_bcd;

  localparam int W = 26;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          rstN = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  binIn = '0;
  logic          ready;
  logic          done;
  logic [4*D-1:0] bcdOut;

  int checks = 0;
  int errors = 0;

  time_to_bcd #(.WIDTH(W), .DIGITS(D)) dut (
    .clk(clk), .rstN(rstN), .start(start), .binIn(binIn),
    .ready(ready), .done(done), .bcdOut(bcdOut)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits by repeated division, independent of the
  // shift-and-add algorithm.
  function automatic logic [31:0] ref_bcd(input longint unsigned v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one conversion from IDLE and observes it. It makes no judgement.
  // k counts samples taken 1 time unit after each edge, with k=0 right after
  // the accepting edge.
  task automatic run_conv(input logic [W-1:0] v, output logic [31:0] res,
                          output int lat, output int busy, output int pulses,
                          output bit stable, output bit overlap,
                          output bit timeout);
    logic [31:0] prev;
    res = '0; lat = -1; busy = 0; pulses = 0;
    stable = 1'b1; overlap = 1'b0; timeout = 1'b1;
    binIn = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    prev = bcdOut;
    for (int k = 0; k < 100; k++) begin
      binIn = W'($urandom);
      if (!ready) busy++;
      if (done && ready) overlap = 1'b1;
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          res = bcdOut;
        end
      end else if (pulses == 0 && bcdOut !== prev) begin
        stable = 1'b0;
      end
      if (ready) begin
        timeout = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #1 rstN = 1'b0;
    #2;
    checks++;
    if (ready !== 1'b0 || done !== 1'b0 || bcdOut !== 32'h0) begin
      errors++;
      $display("FAIL reset_state ready=%b done=%b bcd=%h want 0 0 0", ready, done, bcdOut);
    end
    @(negedge clk);
    @(negedge clk);
    rstN  = 1'b1;
    start = 1'b1;
    binIn = W'(5);
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", ready);
    end
    tick();
    start = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL first_edge_accept ready=%b want 0", ready);
    end
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (done) begin seen = 1'b1; break; end
        tick();
      end
      checks++;
      if (!seen || bcdOut !== 32'h5) begin
        errors++;
        $display("FAIL reset_first_conv seen=%b bcd=%h want 00000005", seen, bcdOut);
      end
    end
    tick();
  endtask

  task automatic test_vectors();
    logic [W-1:0] vals [5] = '{W'(0), W'(12345678), W'(67108863), W'(9), W'(10)};
    logic [31:0]  exp  [5] = '{32'h0, 32'h12345678, 32'h67108863, 32'h9, 32'h10};
    logic [31:0] res;
    int lat, busy, pulses;
    bit stable, overlap, timeout;
    for (int i = 0; i < 5; i++) begin
      run_conv(vals[i], res, lat, busy, pulses, stable, overlap, timeout);
      checks++;
      if (timeout || res !== exp[i]) begin
        errors++;
        $display("FAIL vec%0d_value got %h want %h timeout=%b", i, res, exp[i], timeout);
      end
      checks++;
      if (lat != 27 || busy != 28 || pulses != 1) begin
        errors++;
        $display("FAIL vec%0d_timing lat=%0d busy=%0d pulses=%0d want 27 28 1",
                 i, lat, busy, pulses);
      end
      checks++;
      if (!stable || overlap) begin
        errors++;
        $display("FAIL vec%0d_hold stable=%b overlap=%b want 1 0", i, stable, overlap);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] a;
    bit seen = 1'b0;
    a = W'(4321);
    binIn = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k == 5) begin
        start = 1'b1;
        binIn = W'(777);
      end else begin
        start = 1'b0;
        binIn = W'($urandom);
      end
      if (done) begin seen = 1'b1; break; end
      tick();
    end
    start = 1'b0;
    checks++;
    if (!seen || bcdOut !== ref_bcd(64'(a))) begin
      errors++;
      $display("FAIL ignore_start seen=%b got %h want %h", seen, bcdOut, ref_bcd(64'(a)));
    end
    tick();
    tick();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL start_not_queued ready=%b want 1", ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q[$];
    logic [W-1:0] e;
    int last = -1;
    int ndone = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      start = (cyc < 120);
      binIn = W'($urandom);
      if (ready && start) q.push_back(binIn);
      tick();
      if (done && ready) begin
        checks++;
        errors++;
        $display("FAIL b2b_overlap cyc=%0d done and ready both high", cyc);
      end
      if (done) begin
        ndone++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_spurious_done cyc=%0d got done want none", cyc);
        end else begin
          e = q.pop_front();
          if (bcdOut !== ref_bcd(64'(e))) begin
            errors++;
            $display("FAIL b2b_value got %h want %h", bcdOut, ref_bcd(64'(e)));
          end
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 29) begin
            errors++;
            $display("FAIL b2b_period got %0d want 29", cyc - last);
          end
        end
        last = cyc;
      end
      if (cyc >= 120 && ready && q.size() == 0) break;
    end
    start = 1'b0;
    checks++;
    if (ndone < 4 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count done=%0d pending=%0d want >=4 0", ndone, q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat, busy, pulses;
    bit stable, overlap, timeout;
    bit saw_done = 1'b0;
    binIn = W'(12345678);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    #2 rstN = 1'b0;
    #1;
    checks++;
    if (bcdOut !== 32'h0 || done !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async bcd=%h done=%b ready=%b want 0 0 0", bcdOut, done, ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    @(negedge clk);
    rstN = 1'b1;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_done || bcdOut !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_abandon done_seen=%b bcd=%h want 0 0", saw_done, bcdOut);
    end
    tick();
    run_conv(W'(99), res, lat, busy, pulses, stable, overlap, timeout);
    checks++;
    if (timeout || res !== 32'h99) begin
      errors++;
      $display("FAIL post_reset_conv got %h want 00000099", res);
    end
  endtask

  task automatic test_random();
    logic [31:0] res;
    logic [W-1:0] v;
    int lat, busy, pulses;
    bit stable, overlap, timeout;
    bit bad_digit;
    for (int n = 0; n < 1000; n++) begin
      case (n % 4)
        0:       v = W'($urandom_range(0, 99));
        1:       v = W'($urandom_range(0, 99999));
        default: v = W'($urandom);
      endcase
      run_conv(v, res, lat, busy, pulses, stable, overlap, timeout);
      bad_digit = 1'b0;
      for (int i = 0; i < D; i++) if (res[4*i +: 4] > 4'd9) bad_digit = 1'b1;
      checks++;
      if (timeout || bad_digit || res !== ref_bcd(64'(v)) || lat != 27 || pulses != 1) begin
        errors++;
        $display("FAIL random%0d in=%0d got %h want %h lat=%0d pulses=%0d",
                 n, v, res, ref_bcd(64'(v)), lat, pulses);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
